// File: rtl/fp_comp_sched.sv
// Round-robin scheduler sharing one floating-point comparator among N requesters.
// One grant at a time: launch, wait for done (bounded by TO cycles), return flags.
module fp_comp_sched #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int TO = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] op_a,
    input  logic [N*W-1:0] op_b,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic           rsp_less,
    output logic           rsp_eq,
    output logic           rsp_great,
    output logic           rsp_inv,
    output logic           timeout_err,
    output logic           busy,
    output logic [W-1:0]   cmp_in1,
    output logic [W-1:0]   cmp_in2,
    output logic           cmp_act,
    input  logic           cmp_less,
    input  logic           cmp_eq,
    input  logic           cmp_great,
    input  logic           cmp_inv,
    input  logic           cmp_done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TO) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   id;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   win_id;
    logic            win_found;
    logic [2*N-1:0]  rot;

    // Rotate the doubled request vector so bit 0 is the requester just after last.
    always_comb begin
        rot       = {req, req} >> (32'(last) + 32'd1);
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!win_found && rot[j]) begin
                win_found = 1'b1;
                win_id    = IW'((32'(last) + 32'd1 + j) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last        <= IW'(N - 1);
            id          <= '0;
            cnt         <= '0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_less    <= 1'b0;
            rsp_eq      <= 1'b0;
            rsp_great   <= 1'b0;
            rsp_inv     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            cmp_in1     <= '0;
            cmp_in2     <= '0;
            cmp_act     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        id      <= win_id;
                        cmp_in1 <= op_a[32'(win_id)*W +: W];
                        cmp_in2 <= op_b[32'(win_id)*W +: W];
                        gnt     <= N'(1) << win_id;
                        cmp_act <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt     <= '0;
                    cmp_act <= 1'b0;
                    cnt     <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // done takes precedence over an expiring counter in the same cycle
                    if (cmp_done) begin
                        {rsp_less, rsp_eq, rsp_great, rsp_inv} <=
                            {cmp_less, cmp_eq, cmp_great, cmp_inv};
                        rsp_valid <= N'(1) << id;
                        state     <= RESP;
                    end else if (cnt == CW'(TO - 1)) begin
                        {rsp_less, rsp_eq, rsp_great, rsp_inv} <= 4'b0001;
                        rsp_valid   <= N'(1) << id;
                        timeout_err <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid   <= '0;
                    timeout_err <= 1'b0;
                    last        <= id;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
